// File: rtl/axis_ram_ring_writer.sv
// AXI-Stream to AXI3 burst writer feeding a circular buffer in PS RAM.
// Bursts are gated by ring occupancy against the reader pointer and by the number of outstanding B responses.
module axis_ram_ring_writer #(
   parameter int AXI_ID_WIDTH    = 6,
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int AXI_DATA_WIDTH  = 64,
   parameter int CNT_WIDTH       = 16,
   parameter int BURST_LEN       = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [AXI_ADDR_WIDTH-1:0]     base_addr,
   input  logic [CNT_WIDTH-1:0]          ring_bursts_cfg,
   input  logic                          wrap_en,
   input  logic [CNT_WIDTH-1:0]          reader_burst_ptr,
   output logic [CNT_WIDTH-1:0]          bursts_issued_sts,
   output logic [CNT_WIDTH-1:0]          bursts_done_sts,
   output logic [CNT_WIDTH-1:0]          wrap_count_sts,
   output logic                          full_sts,
   output logic                          done_sts,
   output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
   output logic [3:0]                    m_axi_awlen,
   output logic [2:0]                    m_axi_awsize,
   output logic [1:0]                    m_axi_awburst,
   output logic [3:0]                    m_axi_awcache,
   output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [AXI_ID_WIDTH-1:0]       m_axi_wid,
   output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                          m_axi_wlast,
   output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
   localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);
   localparam logic [2:0] AW_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
   localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_LEN * (AXI_DATA_WIDTH / 8));

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] issued_q, issued_d;
   logic [CNT_WIDTH-1:0] bdone_q, bdone_d;
   logic [CNT_WIDTH-1:0] wraps_q, wraps_d;
   logic [CNT_WIDTH-1:0] idx_q, idx_d;
   logic [CNT_WIDTH-1:0] cfg_q, cfg_d;
   logic                 wrap_en_q, wrap_en_d;
   logic                 full_q, full_d;
   logic [3:0]           beat_q, beat_d;
   logic [OW-1:0]        outst_q, outst_d;

   logic [CNT_WIDTH-1:0] ring_used;
   logic                 ring_full, aw_hs, w_hs, b_hs, last_beat;

   // Occupancy is taken modulo 2^CNT_WIDTH so free-running pointers may wrap.
   assign ring_used = issued_q - reader_burst_ptr;
   assign ring_full = (ring_used >= ring_bursts_cfg);
   assign last_beat = (beat_q == LAST_BEAT);
   assign aw_hs     = (state_q == S_ADDR) && m_axi_awready;
   assign w_hs      = (state_q == S_DATA) && s_axis_tvalid && m_axi_wready;
   assign b_hs      = m_axi_bvalid && m_axi_bready && (outst_q != '0);

   always_comb begin
      state_d   = state_q;
      issued_d  = issued_q;
      bdone_d   = bdone_q;
      wraps_d   = wraps_q;
      idx_d     = idx_q;
      cfg_d     = cfg_q;
      wrap_en_d = wrap_en_q;
      full_d    = 1'b0;
      beat_d    = beat_q;
      outst_d   = outst_q;

      if (aw_hs && !b_hs)      outst_d = outst_q + 1'b1;
      else if (b_hs && !aw_hs) outst_d = outst_q - 1'b1;
      if (aw_hs) issued_d = issued_q + 1'b1;
      if (b_hs)  bdone_d  = bdone_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            full_d = ring_full;
            if ((ring_bursts_cfg != '0) && !ring_full && (outst_q < MAX_OUT)) begin
               cfg_d     = ring_bursts_cfg;
               wrap_en_d = wrap_en;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            if (m_axi_awready) state_d = S_DATA;
         end
         S_DATA: begin
            if (w_hs) begin
               if (last_beat) begin
                  beat_d = '0;
                  if (idx_q == cfg_q - 1'b1) begin
                     idx_d   = '0;
                     wraps_d = wraps_q + 1'b1;
                     state_d = wrap_en_q ? S_IDLE : S_DRAIN;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (outst_q == '0) state_d = S_DONE;
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= S_IDLE;
         issued_q  <= '0;
         bdone_q   <= '0;
         wraps_q   <= '0;
         idx_q     <= '0;
         cfg_q     <= '0;
         wrap_en_q <= 1'b0;
         full_q    <= 1'b0;
         beat_q    <= '0;
         outst_q   <= '0;
      end else begin
         state_q   <= state_d;
         issued_q  <= issued_d;
         bdone_q   <= bdone_d;
         wraps_q   <= wraps_d;
         idx_q     <= idx_d;
         cfg_q     <= cfg_d;
         wrap_en_q <= wrap_en_d;
         full_q    <= full_d;
         beat_q    <= beat_d;
         outst_q   <= outst_d;
      end
   end

   assign bursts_issued_sts = issued_q;
   assign bursts_done_sts   = bdone_q;
   assign wrap_count_sts    = wraps_q;
   assign full_sts          = full_q;
   assign done_sts          = (state_q == S_DONE);

   assign m_axi_awid    = '0;
   assign m_axi_awlen   = LAST_BEAT;
   assign m_axi_awsize  = AW_SIZE;
   assign m_axi_awburst = 2'b01;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awaddr  = base_addr + AXI_ADDR_WIDTH'(idx_q) * BURST_BYTES;
   assign m_axi_awvalid = (state_q == S_ADDR);

   // W is a straight pass-through of the stream while a burst is open.
   assign m_axi_wid     = '0;
   assign m_axi_wstrb   = '1;
   assign m_axi_wdata   = s_axis_tdata;
   assign m_axi_wvalid  = (state_q == S_DATA) && s_axis_tvalid;
   assign m_axi_wlast   = (state_q == S_DATA) && last_beat;
   assign s_axis_tready = (state_q == S_DATA) && m_axi_wready;
   assign m_axi_bready  = ~areset;

endmodule
